channel_arbiter: RTL and testbench
==================================

Name: channel_arbiter

Overview:
- Per-output-port round-robin arbiter that drives the one-hot SEL of the downstream channel_mux.
- Grants one input port at a time and holds the grant for a whole packet, until that port's LAST flit transfers.
- Handshakes flits between the input buffers and the downstream stage.
- Enforces a maximum packet length with a forced release and an error pulse.

Parameters:
- Numports, 4: number of input ports; sets the width of all per-port vectors.
- PortNo, 1: index of the output port this arbiter serves. Requests from this index are masked (no U-turn).
- MaxFlits, 8: maximum flits per packet. Reaching it without LAST forces release.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-low (0 = reset).
- REQ  input  Numports  per-port request for this output, from the input buffer head.
- VALID  input  Numports  per-port flit valid.
- LAST  input  Numports  per-port last-flit-of-packet marker; meaningful only with VALID.
- READY  input  1  downstream can accept a flit this cycle.
- SEL  output  Numports  registered one-hot grant; feeds channel_mux SEL. All-zero when idle.
- GNT  output  Numports  combinational pop strobe: SEL & {Numports{READY}}.
- Q_VALID  output  1  |(SEL & VALID).
- Q_LAST  output  1  |(SEL & VALID & LAST).
- BUSY  output  1  registered; 1 while a grant is held.
- ERR  output  1  registered one-cycle pulse on a MaxFlits overrun.

Behaviour:
- Reset, asynchronous on RST=0:
  - SEL=0, BUSY=0, ERR=0, round-robin pointer PTR=0, flit counter CNT=0.
  - Q_VALID, Q_LAST and GNT are therefore 0.
  - Reset mid-packet drops the grant immediately. There is no flush.
- Masked request set: MREQ = REQ with bit PortNo forced to 0.
- FSM state IDLE (BUSY=0):
  - If MREQ is nonzero, the winner is the first set bit scanning PTR, PTR+1, ... modulo Numports.
  - Next edge: SEL = onehot(winner), BUSY=1, CNT=0.
  - Request-to-SEL latency is 1 cycle.
  - If MREQ is 0, stay in IDLE.
- FSM state BUSY:
  - SEL is frozen. REQ changes are ignored, including deassertion of the granted REQ.
  - A transfer happens in any cycle with Q_VALID=1 and READY=1. Each transfer increments CNT.
  - VALID=1 with READY=0: no transfer, no state change. The input must hold its flit (standard valid/ready).
- Release conditions (evaluated on a transfer cycle):
  - Q_LAST=1 → normal release.
  - CNT = MaxFlits-1 and Q_LAST=0 → forced release; ERR pulses high for exactly 1 cycle on the next edge.
- On release:
  - PTR ← (granted index + 1) mod Numports.
  - Arbitration runs in the same cycle over MREQ using the updated PTR, so the just-served port has lowest priority. The granted port's REQ counts only if still asserted.
  - If a winner exists: SEL switches directly to the new one-hot on the next edge, BUSY stays 1, CNT=0. This gives zero bubble cycles between packets.
  - Otherwise: SEL=0 and BUSY=0 on the next edge.
- Single-flit packet (VALID and LAST on the first transfer): the grant is held for exactly one transfer cycle.
- Numports=1 with PortNo=0: MREQ is always 0 and the arbiter never grants. This is legal.
- CNT width is clog2(MaxFlits)+1. CNT saturates and never wraps, because release occurs at MaxFlits-1.
- No combinational path from READY to SEL. READY reaches only GNT.

Test Plan:
- Reset then REQ=4'b0001 with VALID[0]=1, LAST[0] high on the 3rd flit, READY=1 → SEL=4'b0001 one cycle after REQ; GNT[0] high for 3 cycles; SEL=0 and BUSY=0 the cycle after; PTR=1.
- REQ=4'b0010 only (PortNo=1) → SEL stays 0, BUSY stays 0 for 20 cycles.
- REQ=4'b1101 held, 2-flit packets, READY=1 → grant order port 0, 2, 3, 0, 2, ...; SEL changes on the cycle after each LAST transfer with no all-zero cycle in between.
- Port 2 granted, VALID[2]=1, READY toggles 1,0,0,1,1 with LAST on the 3rd accepted flit → GNT[2]=READY every cycle; CNT advances only on READY=1 cycles; release after the 5th cycle.
- Port 3 granted, LAST never asserted, READY=1 → after 8 transfers SEL=0 and ERR=1 for exactly 1 cycle; PTR=0.
- Port 0 granted mid-packet, drive RST=0 between clock edges → SEL=0, BUSY=0 and GNT=0 immediately, without waiting for an edge; after release with REQ=4'b0001, regrant to port 0 one cycle later.

Source files
------------

// File: rtl/channel_arbiter.sv
// Round-robin packet arbiter for one output port: holds a one-hot grant for a whole
// packet, handshakes flits, and force-releases packets that exceed MaxFlits.
//
// state  | meaning
// S_IDLE | no grant held, SEL=0, arbitrating every cycle over masked requests
// S_BUSY | grant held in SEL until the granted port's LAST transfers or MaxFlits is hit
module channel_arbiter #(
    parameter int Numports = 4,
    parameter int PortNo   = 1,
    parameter int MaxFlits = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Numports-1:0] REQ,
    input  logic [Numports-1:0] VALID,
    input  logic [Numports-1:0] LAST,
    input  logic                READY,
    output logic [Numports-1:0] SEL,
    output logic [Numports-1:0] GNT,
    output logic                Q_VALID,
    output logic                Q_LAST,
    output logic                BUSY,
    output logic                ERR
);

    localparam int PW = (Numports > 1) ? $clog2(Numports) : 1;
    localparam int CW = $clog2(MaxFlits) + 1;
    localparam logic [CW-1:0] CntLast = CW'(MaxFlits - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [Numports-1:0] r_sel;
    logic [Numports-1:0] w_sel_nxt;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic [Numports-1:0] w_mreq;
    logic                w_qvalid;
    logic                w_qlast;
    logic                w_xfer;
    logic                w_release;
    logic [PW-1:0]       w_gidx;
    logic [PW-1:0]       w_ptr_rel;
    logic [PW-1:0]       w_arb_ptr;
    logic                w_win_vld;
    logic [Numports-1:0] w_win_oh;

    always_comb begin
        for (int i = 0; i < Numports; i++) begin
            w_mreq[i] = REQ[i] & (i != PortNo);
        end
    end

    assign w_qvalid  = |(r_sel & VALID);
    assign w_qlast   = |(r_sel & VALID & LAST);
    assign w_xfer    = w_qvalid & READY;
    assign w_release = (r_state == S_BUSY) & w_xfer & (w_qlast | (r_cnt == CntLast));

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < Numports; i++) begin
            if (r_sel[i]) begin
                w_gidx = PW'(i);
            end
        end
    end

    assign w_ptr_rel = (w_gidx == PW'(Numports - 1)) ? '0 : w_gidx + 1'b1;
    // On a release cycle arbitration already sees the advanced pointer, so the
    // just-served port has lowest priority and the next grant follows with no bubble.
    assign w_arb_ptr = w_release ? w_ptr_rel : r_ptr;

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        w_win_vld = 1'b0;
        w_win_oh  = '0;
        for (int k = 0; k < Numports; k++) begin
            sum = {1'b0, w_arb_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(Numports)) begin
                sum = sum - (PW+1)'(Numports);
            end
            idx = sum[PW-1:0];
            if (!w_win_vld && w_mreq[idx]) begin
                w_win_vld     = 1'b1;
                w_win_oh      = '0;
                w_win_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_BUSY;
                    w_sel_nxt   = w_win_oh;
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt = w_ptr_rel;
                    w_err_nxt = ~w_qlast;
                    w_cnt_nxt = '0;
                    if (w_win_vld) begin
                        w_sel_nxt = w_win_oh;
                    end else begin
                        w_sel_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_xfer && (r_cnt != CntLast)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    // READY feeds only GNT; SEL/BUSY/ERR come straight from registers.
    always_comb begin
        SEL     = r_sel;
        GNT     = r_sel & {Numports{READY}};
        Q_VALID = w_qvalid;
        Q_LAST  = w_qlast;
        BUSY    = (r_state == S_BUSY);
        ERR     = r_err;
    end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: stimulus pushes expected flits into a scoreboard
// queue, a forked monitor pops and compares on every presented transfer.
module tb_channel_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] VALID;
    logic [3:0] LAST;
    logic       READY;
    logic [3:0] SEL;
    logic [3:0] GNT;
    logic       Q_VALID;
    logic       Q_LAST;
    logic       BUSY;
    logic       ERR;

    typedef struct packed {
        logic [1:0] port;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    channel_arbiter #(.Numports(4), .PortNo(1), .MaxFlits(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .VALID  (VALID),
        .LAST   (LAST),
        .READY  (READY),
        .SEL    (SEL),
        .GNT    (GNT),
        .Q_VALID(Q_VALID),
        .Q_LAST (Q_LAST),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int p, input logic l);
        exp_t e;
        e.port = 2'(p);
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST && Q_VALID && READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon_unexpected: got SEL=%0h with empty scoreboard at %0t", SEL, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_sel", 32'(SEL), 32'(4'b0001 << e.port));
                    chk("mon_last", 32'(Q_LAST), 32'(e.last));
                end
            end
        end
    endtask

    initial begin
        int         order [6];
        logic [4:0] rdy;
        order = '{0, 2, 3, 0, 2, 3};
        rdy   = 5'b11001;
        n_checks = 0;
        n_errors = 0;
        RST   = 1'b0;
        REQ   = 4'hf;
        VALID = 4'hf;
        LAST  = 4'h0;
        READY = 1'b1;
        fork
            monitor();
        join_none

        // reset holds everything idle even with requests present
        #12;
        chk("rst_sel", 32'(SEL), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_qvalid", 32'(Q_VALID), 0);
        REQ   = 4'h0;
        VALID = 4'h0;
        #1 RST = 1'b1;
        tick();

        // single port, 3-flit packet
        REQ = 4'b0001; VALID = 4'b0001; LAST = 4'b0000; READY = 1'b1;
        push(0, 0); push(0, 0); push(0, 1);
        #1 chk("t1_sel_pre", 32'(SEL), 0);
        tick();
        chk("t1_sel", 32'(SEL), 32'h1);
        chk("t1_busy", 32'(BUSY), 1);
        tick();
        chk("t1_sel_hold", 32'(SEL), 32'h1);
        tick();
        LAST = 4'b0001; REQ = 4'b0000;
        tick();
        chk("t1_sel_rel", 32'(SEL), 0);
        chk("t1_busy_rel", 32'(BUSY), 0);
        VALID = 4'h0; LAST = 4'h0;

        // pointer is 1 now: 3 beats 0
        REQ = 4'b1001; VALID = 4'b1001; LAST = 4'b1001;
        push(3, 1);
        tick();
        chk("t1b_ptr_sel", 32'(SEL), 32'h8);
        REQ = 4'h0;
        tick();
        chk("t1b_sel_rel", 32'(SEL), 0);
        chk("t1b_busy_rel", 32'(BUSY), 0);
        VALID = 4'h0; LAST = 4'h0;

        // own-port request is masked
        REQ = 4'b0010; VALID = 4'b0010; LAST = 4'b0010;
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("t2_sel", 32'(SEL), 0);
            chk("t2_busy", 32'(BUSY), 0);
        end
        REQ = 4'h0; VALID = 4'h0; LAST = 4'h0;

        // round robin of 2-flit packets, no bubbles
        REQ = 4'b1101; VALID = 4'b1101; LAST = 4'h0;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t3_sel_first", 32'(SEL), 32'(4'b0001 << order[i]));
            chk("t3_busy", 32'(BUSY), 1);
            push(order[i], 0); push(order[i], 1);
            LAST = 4'h0;
            tick();
            chk("t3_sel_second", 32'(SEL), 32'(4'b0001 << order[i]));
            LAST = 4'hf;
            if (i == 5) REQ = 4'h0;
            tick();
        end
        chk("t3_sel_end", 32'(SEL), 0);
        chk("t3_busy_end", 32'(BUSY), 0);
        VALID = 4'h0; LAST = 4'h0;

        // backpressure on port 2
        REQ = 4'b0100; VALID = 4'b0100; LAST = 4'h0; READY = 1'b1;
        tick();
        chk("t4_sel", 32'(SEL), 32'h4);
        push(2, 0); push(2, 0); push(2, 1);
        for (int j = 0; j < 5; j++) begin
            READY = rdy[j];
            LAST  = (j == 4) ? 4'b0100 : 4'b0000;
            if (j == 4) REQ = 4'h0;
            #1;
            chk("t4_gnt", 32'(GNT), rdy[j] ? 32'h4 : 32'h0);
            chk("t4_sel_hold", 32'(SEL), 32'h4);
            tick();
        end
        chk("t4_sel_rel", 32'(SEL), 0);
        chk("t4_busy_rel", 32'(BUSY), 0);
        VALID = 4'h0; LAST = 4'h0; READY = 1'b1;

        // overrun on port 3: forced release after 8 transfers
        REQ = 4'b1000; VALID = 4'b1000; LAST = 4'h0;
        tick();
        chk("t5_sel", 32'(SEL), 32'h8);
        for (int j = 0; j < 8; j++) begin
            push(3, 0);
            chk("t5_sel_hold", 32'(SEL), 32'h8);
            chk("t5_err_low", 32'(ERR), 0);
            if (j == 7) REQ = 4'h0;
            tick();
        end
        chk("t5_sel_rel", 32'(SEL), 0);
        chk("t5_busy_rel", 32'(BUSY), 0);
        chk("t5_err_pulse", 32'(ERR), 1);
        tick();
        chk("t5_err_clear", 32'(ERR), 0);
        VALID = 4'h0;

        // pointer is 0 now: 0 beats 3; then async reset mid-packet
        REQ = 4'b1001; VALID = 4'b1001; LAST = 4'h0; READY = 1'b0;
        tick();
        chk("t6_sel", 32'(SEL), 32'h1);
        READY = 1'b1;
        push(0, 0);
        #1 chk("t6_gnt", 32'(GNT), 32'h1);
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("t6_rst_sel", 32'(SEL), 0);
        chk("t6_rst_busy", 32'(BUSY), 0);
        chk("t6_rst_gnt", 32'(GNT), 0);
        REQ = 4'b0001; VALID = 4'b0001; LAST = 4'b0001;
        #1 RST = 1'b1;
        tick();
        chk("t6_regrant", 32'(SEL), 32'h1);
        push(0, 1);
        REQ = 4'h0;
        tick();
        chk("t6_sel_rel", 32'(SEL), 0);
        chk("t6_busy_rel", 32'(BUSY), 0);
        VALID = 4'h0; LAST = 4'h0;

        tick();
        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
